// File: rtl/l2_write_buffer.sv
// rtl/l2_write_buffer.sv - line-granular write buffer between the L1 arbiter and L2
//
// Line writes (L1 evictions) are accepted into a small circular FIFO and acked
// in two cycles; buffered lines drain to L2 whenever upstream is idle. Reads
// that hit a buffered line are served from the buffer, read misses pass
// straight through to L2.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   up_read         line read from arbiter, held until up_resp
//   up_write        line write from arbiter, held until up_resp
//   up_address      request address (offset bits ignored)
//   up_wdata        write line
//   up_resp         one-cycle completion pulse to arbiter
//   up_rdata        read line, valid with up_resp on a read
//   mem_read        L2 read, held until mem_resp
//   mem_write       L2 write, held until mem_resp
//   mem_address     L2 line address (offset bits zero)
//   mem_wdata       L2 write line
//   mem_resp        L2 completion pulse
//   mem_rdata       L2 read line, valid with mem_resp
//   wb_empty        no lines buffered
module l2_write_buffer #(
  parameter int s_offset = 5,
  parameter int s_line   = 8 * 2**s_offset,
  parameter int DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_read,
  input  logic              up_write,
  input  logic [31:0]       up_address,
  input  logic [s_line-1:0] up_wdata,
  output logic              up_resp,
  output logic [s_line-1:0] up_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [s_line-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [s_line-1:0] mem_rdata,
  output logic              wb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = 32 - s_offset;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    READ_MISS,
    DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       head_q, tail_q;
  logic [CW-1:0]       count_q, count_d;
  logic [DEPTH-1:0]    valid_q;
  logic [LW-1:0]       line_q [DEPTH];
  logic [s_line-1:0]   data_q [DEPTH];
  logic [s_line-1:0]   rdata_q;
  logic                wb_empty_q;

  logic [LW-1:0]       up_line;
  logic                hit;
  logic [PW-1:0]       hit_idx;
  logic                do_coalesce, do_enq, do_hit_read, do_pop;

  // Byte-offset bits of the request never matter at line granularity.
  logic unused_offset;
  assign unused_offset = ^up_address[s_offset-1:0];

  assign up_line = up_address[31:s_offset];

  // Coalescing guarantees a line address lives in at most one entry, so the
  // last-match-wins loop never has to arbitrate between real hits.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (line_q[i] == up_line)) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    do_coalesce = 1'b0;
    do_enq      = 1'b0;
    do_hit_read = 1'b0;
    do_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (up_write) begin
          if (hit) begin
            do_coalesce = 1'b1;
            state_d     = ACK;
          end else if (count_q != CW'(DEPTH)) begin
            do_enq  = 1'b1;
            state_d = ACK;
          end else begin
            // Full: make room by draining the oldest line; the write stays
            // pending upstream and is taken on the return to IDLE.
            state_d = DRAIN;
          end
        end else if (up_read) begin
          if (hit) begin
            do_hit_read = 1'b1;
            state_d     = ACK;
          end else begin
            state_d = READ_MISS;
          end
        end else if (count_q != '0) begin
          state_d = DRAIN;
        end
      end
      ACK: state_d = IDLE;
      READ_MISS: begin
        if (mem_resp) state_d = IDLE;
      end
      DRAIN: begin
        if (mem_resp) begin
          do_pop  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (do_enq)      count_d = count_q + CW'(1);
    else if (do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      wb_empty_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wb_empty_q <= (count_d == '0);
      if (do_enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (do_pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
    end
  end

  // Payload storage carries no reset: it is only ever read under a valid bit
  // or after being freshly latched.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      line_q[tail_q] <= up_line;
      data_q[tail_q] <= up_wdata;
    end
    if (do_coalesce) begin
      data_q[hit_idx] <= up_wdata;
    end
    if (do_hit_read) begin
      rdata_q <= data_q[hit_idx];
    end
  end

  always_comb begin
    up_resp     = 1'b0;
    up_rdata    = rdata_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = data_q[head_q];
    case (state_q)
      ACK: up_resp = 1'b1;
      READ_MISS: begin
        // No buffered line aliases this address, so L2 data is current.
        mem_read    = 1'b1;
        mem_address = {up_line, {s_offset{1'b0}}};
        up_resp     = mem_resp;
        up_rdata    = mem_rdata;
      end
      DRAIN: begin
        mem_write   = 1'b1;
        mem_address = {line_q[head_q], {s_offset{1'b0}}};
      end
      default: ;
    endcase
  end

  assign wb_empty = wb_empty_q;

endmodule
